// File: rtl/mul_product_sequencer_if.sv
// Operand and result handshake bundle between the execute-stage operand source,
// the product sequencer and the result consumer.
interface mul_product_sequencer_if #(
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_src1;
   logic [31:0]      in_src2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_src1, in_src2, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  in_valid, in_src1, in_src2, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );
endinterface

// File: rtl/mul_product_sequencer.sv
// Drives one 32x32 multiply through a 16x16 partial-product cell and folds the
// three returned partials into the low 32 product bits, returned with its tag.
module mul_product_sequencer #(
   parameter int CELL_LATENCY = 1,
   parameter int TAG_W        = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   mul_product_sequencer_if.slave bus,
   output logic [31:0]           cell_src1,
   output logic [31:0]           cell_src2,
   output logic                  cell_en,
   input  logic [31:0]           cell_p1,
   input  logic [31:0]           cell_p2,
   input  logic [31:0]           cell_p3,
   output logic [15:0]           op_count
);
   localparam int WAIT_W = (CELL_LATENCY > 2) ? $clog2(CELL_LATENCY) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((CELL_LATENCY > 1) ? CELL_LATENCY - 2 : 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_WAIT,
      ST_CAPT,
      ST_SUM,
      ST_DONE
   } state_t;

   state_t           state;
   logic [31:0]      src1_reg;
   logic [31:0]      src2_reg;
   logic             cell_en_reg;
   logic [TAG_W-1:0] tag_reg;
   logic [31:0]      p1_reg;
   logic [15:0]      mid_reg;
   logic [31:0]      result_reg;
   logic [TAG_W-1:0] out_tag_reg;
   logic             valid_reg;
   logic [15:0]      count_reg;
   logic [WAIT_W-1:0] wait_cnt;

   // Only the low halves of the cross partials land inside the low 32 product bits.
   logic unused_high_partials;
   assign unused_high_partials = ^{cell_p2[31:16], cell_p3[31:16]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         src1_reg    <= '0;
         src2_reg    <= '0;
         cell_en_reg <= 1'b0;
         tag_reg     <= '0;
         p1_reg      <= '0;
         mid_reg     <= '0;
         result_reg  <= '0;
         out_tag_reg <= '0;
         valid_reg   <= 1'b0;
         count_reg   <= '0;
         wait_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  src1_reg    <= bus.in_src1;
                  src2_reg    <= bus.in_src2;
                  tag_reg     <= bus.in_tag;
                  cell_en_reg <= 1'b1;
                  state       <= ST_MUL;
               end
            end
            ST_MUL: begin
               cell_en_reg <= 1'b0;
               wait_cnt    <= '0;
               state       <= (CELL_LATENCY > 1) ? ST_WAIT : ST_CAPT;
            end
            ST_WAIT: begin
               // cell_en stays low here so the cell keeps presenting this op's partials
               if (wait_cnt == WAIT_LAST) begin
                  state <= ST_CAPT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_CAPT: begin
               p1_reg  <= cell_p1;
               mid_reg <= cell_p2[15:0] + cell_p3[15:0];
               state   <= ST_SUM;
            end
            ST_SUM: begin
               result_reg  <= p1_reg + {mid_reg, 16'h0000};
               out_tag_reg <= tag_reg;
               valid_reg   <= 1'b1;
               state       <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  valid_reg <= 1'b0;
                  count_reg <= count_reg + 16'd1;
                  // A waiting operand pair is taken in the same cycle the result leaves.
                  if (bus.in_valid) begin
                     src1_reg    <= bus.in_src1;
                     src2_reg    <= bus.in_src2;
                     tag_reg     <= bus.in_tag;
                     cell_en_reg <= 1'b1;
                     state       <= ST_MUL;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               cell_en_reg <= 1'b0;
               valid_reg   <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready   = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
   assign bus.out_valid  = valid_reg;
   assign bus.out_result = result_reg;
   assign bus.out_tag    = out_tag_reg;
   assign cell_src1      = src1_reg;
   assign cell_src2      = src2_reg;
   assign cell_en        = cell_en_reg;
   assign op_count       = count_reg;
endmodule
